// File: rtl/align_shift_sched.sv
// Arbiter and pairing front end for a shared alignment shifter: FP32 requests issue directly,
// while FP16 requests are paired into two lanes or issued alone once the pairing wait expires.
package align_shift_sched_pkg;
  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
endpackage

module align_shift_sched
  import align_shift_sched_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned PAIR_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req32_valid,
  output logic             req32_ready,
  input  logic [23:0]      req32_x,
  input  logic [4:0]       req32_s,
  input  logic [TAG_W-1:0] req32_tag,
  input  logic             req16_valid,
  output logic             req16_ready,
  input  logic [7:0]       req16_x,
  input  logic [3:0]       req16_s,
  input  logic [TAG_W-1:0] req16_tag,
  output fp_fmt_e          sh_fmt,
  output logic [23:0]      sh_x,
  output logic [7:0]       sh_s,
  input  logic [25:0]      sh_r,
  input  logic             sh_sticky_h,
  input  logic             sh_sticky_l,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [25:0]      out_r,
  output logic             out_sticky_h,
  output logic             out_sticky_l,
  output logic [TAG_W-1:0] out_tag_h,
  output logic [TAG_W-1:0] out_tag_l,
  output logic [1:0]       out_lanes
);

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e           state;
  logic [3:0]       wait_cnt;
  logic             rr_ptr;
  logic [7:0]       held_x;
  logic [3:0]       held_s;
  logic [TAG_W-1:0] held_tag;

  logic             slot_free;
  logic             timeout;
  logic             cand16;
  logic             cand32;
  logic             grant16;
  logic             grant32;
  logic             pair;
  logic [TAG_W-1:0] nxt_tag_h;
  logic [TAG_W-1:0] nxt_tag_l;
  logic [1:0]       nxt_lanes;

  assign slot_free = !out_valid || out_ready;
  assign timeout   = (wait_cnt == 4'(PAIR_WAIT));
  assign cand16    = (state == HOLD) && (req16_valid || timeout);
  assign cand32    = req32_valid;

  // Grants are forced low during reset so both readies read 0 while rst is high.
  assign grant32 = !rst && slot_free && cand32 && (!cand16 || !rr_ptr);
  assign grant16 = !rst && slot_free && cand16 && (!cand32 || rr_ptr);
  assign pair    = grant16 && req16_valid;

  assign req32_ready = grant32;
  assign req16_ready = (state == EMPTY) ? !rst : grant16;

  always_comb begin
    sh_fmt    = FP32;
    sh_x      = '0;
    sh_s      = '0;
    nxt_tag_h = '0;
    nxt_tag_l = '0;
    nxt_lanes = 2'b00;
    if (grant32) begin
      sh_x      = req32_x;
      sh_s      = {3'b000, req32_s};
      nxt_tag_l = req32_tag;
      nxt_lanes = 2'b01;
    end else if (grant16) begin
      sh_fmt    = FP16;
      nxt_tag_h = held_tag;
      if (pair) begin
        sh_x      = {held_x, 4'b0000, req16_x, 4'b0000};
        sh_s      = {held_s, req16_s};
        nxt_tag_l = req16_tag;
        nxt_lanes = 2'b11;
      end else begin
        sh_x      = {held_x, 16'h0000};
        sh_s      = {held_s, 4'b0000};
        nxt_lanes = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      wait_cnt     <= '0;
      rr_ptr       <= 1'b0;
      held_x       <= '0;
      held_s       <= '0;
      held_tag     <= '0;
      out_valid    <= 1'b0;
      out_fmt      <= FP32;
      out_r        <= '0;
      out_sticky_h <= 1'b0;
      out_sticky_l <= 1'b0;
      out_tag_h    <= '0;
      out_tag_l    <= '0;
      out_lanes    <= 2'b00;
    end else begin
      if (grant32 || grant16) begin
        out_valid    <= 1'b1;
        out_fmt      <= sh_fmt;
        out_r        <= sh_r;
        out_sticky_h <= sh_sticky_h;
        out_sticky_l <= sh_sticky_l;
        out_tag_h    <= nxt_tag_h;
        out_tag_l    <= nxt_tag_l;
        out_lanes    <= nxt_lanes;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (slot_free && cand16 && cand32) rr_ptr <= !rr_ptr;

      case (state)
        EMPTY: begin
          if (req16_valid) begin
            state    <= HOLD;
            wait_cnt <= '0;
            held_x   <= req16_x;
            held_s   <= req16_s;
            held_tag <= req16_tag;
          end
        end
        HOLD: begin
          if (grant16) begin
            state    <= EMPTY;
            wait_cnt <= '0;
          end else if (!timeout) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_align_shift_sched.sv
// Randomized scoreboard bench for align_shift_sched with a behavioural shifter and a
// queue-based reference model of pairing, timeout and round-robin arbitration.
module tb_align_shift_sched;
  import align_shift_sched_pkg::*;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PAIR_WAIT = 2;

  logic             clk;
  logic             rst;
  logic             req32_valid, req32_ready;
  logic [23:0]      req32_x;
  logic [4:0]       req32_s;
  logic [TAG_W-1:0] req32_tag;
  logic             req16_valid, req16_ready;
  logic [7:0]       req16_x;
  logic [3:0]       req16_s;
  logic [TAG_W-1:0] req16_tag;
  fp_fmt_e          sh_fmt;
  logic [23:0]      sh_x;
  logic [7:0]       sh_s;
  logic [25:0]      sh_r;
  logic             sh_sticky_h, sh_sticky_l;
  logic             out_valid, out_ready;
  fp_fmt_e          out_fmt;
  logic [25:0]      out_r;
  logic             out_sticky_h, out_sticky_l;
  logic [TAG_W-1:0] out_tag_h, out_tag_l;
  logic [1:0]       out_lanes;

  align_shift_sched #(.TAG_W(TAG_W), .PAIR_WAIT(PAIR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req32_valid(req32_valid), .req32_ready(req32_ready), .req32_x(req32_x),
    .req32_s(req32_s), .req32_tag(req32_tag),
    .req16_valid(req16_valid), .req16_ready(req16_ready), .req16_x(req16_x),
    .req16_s(req16_s), .req16_tag(req16_tag),
    .sh_fmt(sh_fmt), .sh_x(sh_x), .sh_s(sh_s), .sh_r(sh_r),
    .sh_sticky_h(sh_sticky_h), .sh_sticky_l(sh_sticky_l),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_r(out_r),
    .out_sticky_h(out_sticky_h), .out_sticky_l(out_sticky_l),
    .out_tag_h(out_tag_h), .out_tag_l(out_tag_l), .out_lanes(out_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    fp_fmt_e          fmt;
    logic [25:0]      r;
    logic             sth;
    logic             stl;
    logic [TAG_W-1:0] th;
    logic [TAG_W-1:0] tl;
    logic [1:0]       lanes;
  } res_t;

  typedef struct packed {
    logic [7:0]       x;
    logic [3:0]       s;
    logic [TAG_W-1:0] tag;
  } half_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  // Behavioural shifter: FP32 shifts {x,2'b00} right by s; FP16 shifts two 13-bit lanes.
  function automatic logic [27:0] shift_fn(fp_fmt_e fmt, logic [23:0] x, logic [7:0] s);
    logic [57:0] w;
    logic [28:0] wh, wl;
    logic [27:0] res;
    if (fmt == FP32) begin
      w   = {x, 2'b00, 32'h0} >> s;
      res = {1'b0, |w[31:0], w[57:32]};
    end else begin
      wh  = {x[23:16], 5'b0, 16'h0} >> s[7:4];
      wl  = {x[11:4], 5'b0, 16'h0} >> s[3:0];
      res = {|wh[15:0], |wl[15:0], wh[28:16], wl[28:16]};
    end
    return res;
  endfunction

  always_comb {sh_sticky_h, sh_sticky_l, sh_r} = shift_fn(sh_fmt, sh_x, sh_s);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic res_t make_res(fp_fmt_e fmt, logic [23:0] x, logic [7:0] s,
                                    logic [TAG_W-1:0] th, logic [TAG_W-1:0] tl,
                                    logic [1:0] lanes);
    res_t r;
    logic [27:0] v;
    v       = shift_fn(fmt, x, s);
    r.fmt   = fmt;
    r.sth   = v[27];
    r.stl   = v[26];
    r.r     = v[25:0];
    r.th    = th;
    r.tl    = tl;
    r.lanes = lanes;
    return r;
  endfunction

  // Reference model: one FP16 waiting slot, an age counter, a fairness flag and the output-slot occupancy.
  half_t held_q[$];
  int    age;
  bit    rr;
  bit    mv;

  initial begin
    logic             hold, slot, c16, c32, g16, g32;
    logic [32:0]      exp_sh;
    logic [23:0]      x;
    logic [7:0]       s;
    logic [TAG_W-1:0] tl;
    half_t            h;
    held_q.delete(); age = 0; rr = 0; mv = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("reset_state",
              {out_valid, out_fmt, out_r, out_sticky_h, out_sticky_l, out_tag_h, out_tag_l,
               out_lanes, req32_ready, req16_ready}, '0);
        held_q.delete(); age = 0; rr = 0; mv = 0;
        exp_q.delete();
      end else begin
        hold = (held_q.size() != 0);
        slot = !mv || out_ready;
        c16  = hold && (req16_valid || age == PAIR_WAIT);
        c32  = req32_valid;
        g16  = 0;
        g32  = 0;
        if (slot) begin
          if (c16 && c32) begin
            if (rr) g16 = 1; else g32 = 1;
            rr = !rr;
          end else begin
            g16 = c16;
            g32 = c32;
          end
        end
        check("ready", {req32_ready, req16_ready}, {g32, hold ? g16 : 1'b1});
        exp_sh = '0;
        if (g32) begin
          exp_sh = {FP32, req32_x, 3'b000, req32_s};
          exp_q.push_back(make_res(FP32, req32_x, {3'b000, req32_s}, '0, req32_tag, 2'b01));
        end
        if (g16) begin
          h  = held_q.pop_front();
          x  = req16_valid ? {h.x, 4'h0, req16_x, 4'h0} : {h.x, 16'h0};
          s  = {h.s, req16_valid ? req16_s : 4'h0};
          tl = req16_valid ? req16_tag : '0;
          exp_sh = {FP16, x, s};
          exp_q.push_back(make_res(FP16, x, s, h.tag, tl, req16_valid ? 2'b11 : 2'b10));
        end else if (hold) begin
          if (age < PAIR_WAIT) age++;
        end
        if (!hold && req16_valid) begin
          held_q.push_back('{x: req16_x, s: req16_s, tag: req16_tag});
          age = 0;
        end
        check("shifter_drive", {sh_fmt, sh_x, sh_s}, exp_sh);
        if (g16 || g32) mv = 1;
        else if (out_ready) mv = 0;
      end
    end
  end

  // Monitor: the head of the queue must be presented, held stable while stalled, and popped on handshake.
  initial begin
    res_t act;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() != 0) begin
          act.fmt = out_fmt; act.r = out_r; act.sth = out_sticky_h; act.stl = out_sticky_l;
          act.th = out_tag_h; act.tl = out_tag_l; act.lanes = out_lanes;
          check("result", act, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    req32_valid = 0; req32_x = '0; req32_s = '0; req32_tag = '0;
    req16_valid = 0; req16_x = '0; req16_s = '0; req16_tag = '0;
  endtask

  task automatic rand32(input bit v);
    req32_valid = v; req32_x = 24'($urandom); req32_s = 5'($urandom); req32_tag = TAG_W'($urandom);
  endtask

  task automatic rand16(input bit v);
    req16_valid = v; req16_x = 8'($urandom); req16_s = 4'($urandom); req16_tag = TAG_W'($urandom);
  endtask

  initial begin
    rst = 1; out_ready = 1; idle();
    tick(2);
    rst = 0;
    tick(1);

    req32_valid = 1; req32_x = 24'h800000; req32_s = 5'd5; req32_tag = 4'd3;
    tick(1);
    idle();
    check("fp32_directed", {out_valid, out_r, out_lanes, out_sticky_h, out_sticky_l},
          {1'b1, 26'h0100000, 2'b01, 2'b00});
    tick(2);

    req16_valid = 1; req16_x = 8'h80; req16_s = 4'd1; req16_tag = 4'd1;
    tick(1);
    req16_x = 8'hC0; req16_s = 4'd2; req16_tag = 4'd2;
    #1;
    check("pair_sh_s", sh_s, 8'h12);
    tick(1);
    idle();
    tick(3);

    req16_valid = 1; req16_x = 8'hA5; req16_s = 4'd3; req16_tag = 4'd5;
    tick(1);
    idle();
    tick(6);

    for (int i = 0; i < 12; i++) begin
      rand32(1); rand16(1);
      tick(1);
    end

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand32(1); rand16(1);
      tick(1);
    end
    out_ready = 1;
    idle();
    tick(6);

    rand32(1); rand16(1);
    tick(1);
    idle();
    rst = 1;
    #1;
    check("reset_async", {out_valid, req32_ready, req16_ready}, 3'b000);
    tick(2);
    rst = 0;
    tick(6);

    for (int i = 0; i < 600; i++) begin
      rand32($urandom_range(0, 99) < 45);
      rand16($urandom_range(0, 99) < 40);
      out_ready = ($urandom_range(0, 99) < 75);
      tick(1);
    end

    idle();
    out_ready = 1;
    tick(10);
    check("drain_empty", {32'(exp_q.size()), 32'(held_q.size())}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
